fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 92 +++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// Pulls 64-bit words from fifo_main and streams them out one byte at a time over a
// valid/ready handshake, LSB-first or MSB-first.
module fifo_reader #(
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      fifo_dout,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [CNT_W-1:0] word_count,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StReq, StLoad, StSend} state_e;

   state_e           state_q, state_d;
   logic [63:0]      shift_q, shift_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_send;
   logic             xfer;
   logic             word_done;

   assign in_send   = (state_q == StSend);
   assign xfer      = in_send && out_ready;
   assign word_done = xfer && (idx_q == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (!fifo_empty) state_d = StReq;
         StReq:  state_d = StLoad;
         StLoad: state_d = StSend;
         StSend: if (word_done) state_d = fifo_empty ? StIdle : StReq;
         default: state_d = StIdle;
      endcase
   end

   // The outgoing byte always sits at the shift register's exit end.
   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (state_q == StLoad) begin
         shift_d = fifo_dout;
         idx_d   = 3'd0;
      end else if (xfer) begin
         if (MSB_FIRST) begin
            shift_d = {shift_q[55:0], 8'h00};
         end else begin
            shift_d = {8'h00, shift_q[63:8]};
         end
         idx_d = idx_q + 3'd1;
         if (word_done) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      fifo_rd_en = (state_q == StReq);
      out_valid  = in_send;
      out_last   = in_send && (idx_q == 3'd7);
      busy       = (state_q != StIdle);
      word_count = cnt_q;
      out_data   = 8'h00;
      if (in_send) begin
         out_data = MSB_FIRST ? shift_q[63:56] : shift_q[7:0];
      end
   end

endmodule
